// File: rtl/hazard_ctrl.sv
// Load-use stall and branch/jump squash control for the IF/ID and ID/EX registers.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           ID_ReadRegNum1,
    input  logic [4:0]           ID_ReadRegNum2,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic                 EX_cntl_MemRead,
    input  logic [4:0]           EX_WriteRegNum,
    input  logic                 EX_redirect,
    output logic                 PCWrite,
    output logic                 IF_IDWrite,
    output logic                 IF_IDFlush,
    output logic                 ID_EXFlush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15 || CNT_WIDTH < 1) begin : g_bad_param
        $error("hazard_ctrl: parameter out of legal range");
    end

    typedef enum logic {
        RUN,
        LD_STALL
    } state_t;

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] rem_cnt, rem_cnt_nxt;
    logic       rs1_hit, rs2_hit, ld_hz;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign rs1_hit = ID_uses_rs1 && (ID_ReadRegNum1 == EX_WriteRegNum);
    assign rs2_hit = ID_uses_rs2 && (ID_ReadRegNum2 == EX_WriteRegNum);
    assign ld_hz   = EX_cntl_MemRead && (EX_WriteRegNum != 5'd0) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            rem_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            rem_cnt <= rem_cnt_nxt;
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_IDFlush  = 1'b0;
        ID_EXFlush  = 1'b0;
        state_nxt   = state;
        rem_cnt_nxt = rem_cnt;
        if (!reset_n) begin
            state_nxt   = RUN;
            rem_cnt_nxt = 4'd0;
        end else if (EX_redirect) begin
            // Wrong-path squash wins over any stall, including one already in progress.
            IF_IDFlush  = 1'b1;
            ID_EXFlush  = 1'b1;
            state_nxt   = RUN;
            rem_cnt_nxt = 4'd0;
        end else if (state == LD_STALL) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXFlush  = 1'b1;
            rem_cnt_nxt = rem_cnt - 4'd1;
            if (rem_cnt <= 4'd1) begin
                state_nxt   = RUN;
                rem_cnt_nxt = 4'd0;
            end
        end else if (ld_hz) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXFlush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nxt   = LD_STALL;
                rem_cnt_nxt = STALL_RELOAD;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!PCWrite && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (EX_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule
